// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath, with a retired-instruction counter.
// Define MEM_WAIT_EN to add the mem_ready handshake that stalls FETCH, MEMRD and MEMWR.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
`ifdef MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    typedef enum logic [3:0] {
        StRst    = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StJump   = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready;

`ifdef MEM_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    always_comb begin
        state_d    = StFetch;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        pc_src     = 2'd0;
        illegal    = 1'b0;
        case (state_q)
            StRst: state_d = StFetch;
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                // PC and IR load only on the completing cycle so a stall cannot double-step PC
                ir_write  = ready;
                pc_en     = ready;
                state_d   = ready ? StDecode : StFetch;
            end
            StDecode: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OpRtype:     state_d = StExec;
                    OpLw, OpSw:  state_d = StMemAdr;
                    OpBeq, OpBne: state_d = StBranch;
                    OpAddi:      state_d = StAddiEx;
                    OpJ:         state_d = StJump;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = ready ? StFetch : StMemWr;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                pc_en     = (opcode == OpBeq) ? zero : ~zero;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = StAddiWb;
            end
            StAddiWb: reg_write = 1'b1;
            StJump: begin
                pc_src = 2'd2;
                pc_en  = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // An instruction retires on the hand-off from its last state back to FETCH
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == StFetch && (state_q inside {StMemWb, StMemWr, StAluWb, StBranch,
                                                   StAddiWb, StJump})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRst;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl; a 4-bit counter makes wrap-around reachable.
module tb_mips_multicycle_ctrl;

    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] SRst = 4'd0, SFetch = 4'd1, SDecode = 4'd2, SMemAdr = 4'd3;
    localparam logic [3:0] SMemRd = 4'd4, SMemWb = 4'd5, SMemWr = 4'd6, SExec = 4'd7;
    localparam logic [3:0] SAluWb = 4'd8, SBranch = 4'd9, SAddiEx = 4'd10, SAddiWb = 4'd11;
    localparam logic [3:0] SJump = 4'd12;

    // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
    //  alu_src_b[1:0],alu_op[1:0],pc_src[1:0],illegal}
    localparam logic [15:0] OFetch = 16'hA820, ODecode = 16'h0060, OIllegal = 16'h0061;
    localparam logic [15:0] OMemAdr = 16'h00C0, OMemRd = 16'h6000, OMemWb = 16'h0300;
    localparam logic [15:0] OMemWr = 16'h5000, OExec = 16'h0090, OAluWb = 16'h0500;
    localparam logic [15:0] OBrTaken = 16'h808A, OBrNot = 16'h008A, OAddiWb = 16'h0100;
    localparam logic [15:0] OJump = 16'h8004;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = 6'h00;
    logic             zero = 1'b0;
`ifdef MEM_WAIT_EN
    logic             mem_ready = 1'b1;
`endif
    logic             pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic             reg_write, alu_src_a, illegal;
    logic [1:0]       alu_src_b, alu_op, pc_src;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;
    logic [15:0]      outs;

    int nchk = 0;
    int nfail = 0;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
`ifdef MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .state      (state),
        .instr_cnt  (instr_cnt)
    );

    assign outs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, alu_op, pc_src, illegal};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [15:0] o);
        tick();
        chk({tag, "_state"}, {28'd0, state}, {28'd0, st});
        chk({tag, "_outs"}, {16'd0, outs}, {16'd0, o});
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
        chk(tag, {{(32-CNT_W){1'b0}}, instr_cnt}, {{(32-CNT_W){1'b0}}, exp});
    endtask

    initial begin
        // T1: reset, then RST -> FETCH -> DECODE
        #12;
        chk("rst_state", {28'd0, state}, {28'd0, SRst});
        chk("rst_outs", {16'd0, outs}, 32'd0);
        chk_cnt("rst_cnt", 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_state", {28'd0, state}, {28'd0, SRst});
        opcode = 6'h23;
        step("t1_fetch", SFetch, OFetch);
        // T2: lw, sw, R-type, addi, j
        step("lw_dec", SDecode, ODecode);
        step("lw_adr", SMemAdr, OMemAdr);
        step("lw_rd", SMemRd, OMemRd);
        step("lw_wb", SMemWb, OMemWb);
        step("lw_end", SFetch, OFetch);
        chk_cnt("cnt_lw", 4'd1);
        opcode = 6'h2B;
        step("sw_dec", SDecode, ODecode);
        step("sw_adr", SMemAdr, OMemAdr);
        step("sw_wr", SMemWr, OMemWr);
        step("sw_end", SFetch, OFetch);
        chk_cnt("cnt_sw", 4'd2);
        opcode = 6'h00;
        step("r_dec", SDecode, ODecode);
        step("r_exec", SExec, OExec);
        step("r_wb", SAluWb, OAluWb);
        step("r_end", SFetch, OFetch);
        chk_cnt("cnt_r", 4'd3);
        opcode = 6'h08;
        step("addi_dec", SDecode, ODecode);
        step("addi_ex", SAddiEx, OMemAdr);
        step("addi_wb", SAddiWb, OAddiWb);
        step("addi_end", SFetch, OFetch);
        chk_cnt("cnt_addi", 4'd4);
        opcode = 6'h02;
        step("j_dec", SDecode, ODecode);
        step("j_jump", SJump, OJump);
        step("j_end", SFetch, OFetch);
        chk_cnt("cnt_j", 4'd5);
        // T3: beq / bne, both zero values
        opcode = 6'h04;
        zero = 1'b1;
        step("beq1_dec", SDecode, ODecode);
        step("beq1_br", SBranch, OBrTaken);
        step("beq1_end", SFetch, OFetch);
        zero = 1'b0;
        step("beq0_dec", SDecode, ODecode);
        step("beq0_br", SBranch, OBrNot);
        step("beq0_end", SFetch, OFetch);
        opcode = 6'h05;
        zero = 1'b1;
        step("bne1_dec", SDecode, ODecode);
        step("bne1_br", SBranch, OBrNot);
        step("bne1_end", SFetch, OFetch);
        zero = 1'b0;
        step("bne0_dec", SDecode, ODecode);
        step("bne0_br", SBranch, OBrTaken);
        step("bne0_end", SFetch, OFetch);
        chk_cnt("cnt_br", 4'd9);
        // T4: illegal opcode
        opcode = 6'h3F;
        step("ill_dec", SDecode, OIllegal);
        step("ill_end", SFetch, OFetch);
        chk_cnt("cnt_ill", 4'd9);
        // T5: asynchronous reset in MEMRD
        opcode = 6'h23;
        step("ab_dec", SDecode, ODecode);
        step("ab_adr", SMemAdr, OMemAdr);
        step("ab_rd", SMemRd, OMemRd);
        rst_n = 1'b0;
        #1;
        chk("ab_state", {28'd0, state}, {28'd0, SRst});
        chk("ab_outs", {16'd0, outs}, 32'd0);
        chk_cnt("ab_cnt", 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("ab_fetch", SFetch, OFetch);
        // Counter wrap: 16 jumps on a 4-bit counter
        opcode = 6'h02;
        for (int i = 0; i < 16; i++) begin
            logic [CNT_W-1:0] want;
            want = CNT_W'(i + 1);
            step("wrap_dec", SDecode, ODecode);
            step("wrap_jump", SJump, OJump);
            step("wrap_end", SFetch, OFetch);
            chk_cnt("wrap_cnt", want);
        end
`ifdef MEM_WAIT_EN
        // T6: stalled fetch and 3-cycle stall in MEMRD
        opcode = 6'h23;
        mem_ready = 1'b0;
        #1;
        chk("wt_fstall", {16'd0, outs}, 32'h2020);
        tick();
        chk("wt_fhold", {28'd0, state}, {28'd0, SFetch});
        mem_ready = 1'b1;
        #1;
        chk("wt_fgo", {16'd0, outs}, {16'd0, OFetch});
        step("wt_dec", SDecode, ODecode);
        step("wt_adr", SMemAdr, OMemAdr);
        step("wt_rd", SMemRd, OMemRd);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("wt_rdhold", SMemRd, OMemRd);
        mem_ready = 1'b1;
        step("wt_wb", SMemWb, OMemWb);
        step("wt_end", SFetch, OFetch);
        chk_cnt("wt_cnt", 4'd1);
`endif
        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
